// File: rtl/tfhe_axi_if.sv
// tfhe_axi_if: AXI4 INCR-only bus (fixed size, ID 0) between the PBS master and its buffer memory
interface tfhe_axi_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64
);
  logic [ADDR_WIDTH-1:0]   S_AXI_AWADDR;
  logic [7:0]              S_AXI_AWLEN;
  logic                    S_AXI_AWVALID;
  logic                    S_AXI_AWREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_WDATA;
  logic [DATA_WIDTH/8-1:0] S_AXI_WSTRB;
  logic                    S_AXI_WLAST;
  logic                    S_AXI_WVALID;
  logic                    S_AXI_WREADY;
  logic [1:0]              S_AXI_BRESP;
  logic                    S_AXI_BVALID;
  logic                    S_AXI_BREADY;
  logic [ADDR_WIDTH-1:0]   S_AXI_ARADDR;
  logic [7:0]              S_AXI_ARLEN;
  logic                    S_AXI_ARVALID;
  logic                    S_AXI_ARREADY;
  logic [DATA_WIDTH-1:0]   S_AXI_RDATA;
  logic [1:0]              S_AXI_RRESP;
  logic                    S_AXI_RLAST;
  logic                    S_AXI_RVALID;
  logic                    S_AXI_RREADY;
  modport slave (
    input  S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID, S_AXI_RREADY,
    output S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
  );
  modport master (
    output S_AXI_AWADDR, S_AXI_AWLEN, S_AXI_AWVALID, S_AXI_WDATA, S_AXI_WSTRB, S_AXI_WLAST,
           S_AXI_WVALID, S_AXI_BREADY, S_AXI_ARADDR, S_AXI_ARLEN, S_AXI_ARVALID, S_AXI_RREADY,
    input  S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BRESP, S_AXI_BVALID, S_AXI_ARREADY,
           S_AXI_RDATA, S_AXI_RRESP, S_AXI_RLAST, S_AXI_RVALID
  );
endinterface

// File: rtl/tfhe_axi_slave_mem.sv
// tfhe_axi_slave_mem: AXI4 slave memory for TFHE ciphertexts/keys, independent read and write burst engines
module tfhe_axi_slave_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 64,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR = 'h40000000,
  parameter int DEPTH = 1024
) (
  input logic       i_clk,
  input logic       i_reset,
  tfhe_axi_if.slave s_axi
);
  localparam int SB = DATA_WIDTH / 8;
  localparam int SH = $clog2(SB);
  localparam int IW = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] DEPTH_A = ADDR_WIDTH'(DEPTH);
  typedef enum logic [1:0] {W_INIT, W_IDLE, W_DATA, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_INIT, R_IDLE, R_DATA} rstate_t;
  function automatic logic [ADDR_WIDTH-1:0] to_word(input logic [ADDR_WIDTH-1:0] a);
    return (a - BASE_ADDR) >> SH;
  endfunction
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DATA_WIDTH-1:0] mem_rd_q;
  wstate_t               wstate_q, wstate_d;
  logic [ADDR_WIDTH-1:0] wword_q, wword_d;
  logic                  wlow_q, wlow_d;
  logic [7:0]            wlen_q, wlen_d, wcnt_q, wcnt_d;
  logic                  werr_q, werr_d;
  logic                  w_in, w_fire, w_end, mem_we;
  always_comb begin
    wstate_d = wstate_q;
    wword_d  = wword_q;
    wlow_d   = wlow_q;
    wlen_d   = wlen_q;
    wcnt_d   = wcnt_q;
    werr_d   = werr_q;
    w_in     = !wlow_q && wword_q < DEPTH_A;
    w_fire   = wstate_q == W_DATA && s_axi.S_AXI_WVALID;
    w_end    = wcnt_q == wlen_q;
    mem_we   = w_fire && w_in;
    case (wstate_q)
      W_INIT: wstate_d = W_IDLE;
      W_IDLE: if (s_axi.S_AXI_AWVALID) begin
        wstate_d = W_DATA;
        wword_d  = to_word(s_axi.S_AXI_AWADDR);
        wlow_d   = s_axi.S_AXI_AWADDR < BASE_ADDR;
        wlen_d   = s_axi.S_AXI_AWLEN;
        wcnt_d   = '0;
        werr_d   = 1'b0;
      end
      W_DATA: if (w_fire) begin
        wword_d  = wword_q + 1'b1;
        wcnt_d   = wcnt_q + 1'b1;
        werr_d   = werr_q | !w_in | (w_end != s_axi.S_AXI_WLAST);
        wstate_d = w_end ? W_RESP : W_DATA;
      end
      default: if (s_axi.S_AXI_BREADY) wstate_d = W_IDLE;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      wstate_q <= W_INIT;
      wword_q  <= '0;
      wlow_q   <= 1'b0;
      wlen_q   <= '0;
      wcnt_q   <= '0;
      werr_q   <= 1'b0;
    end else begin
      wstate_q <= wstate_d;
      wword_q  <= wword_d;
      wlow_q   <= wlow_d;
      wlen_q   <= wlen_d;
      wcnt_q   <= wcnt_d;
      werr_q   <= werr_d;
    end
  end
  assign s_axi.S_AXI_AWREADY = wstate_q == W_IDLE;
  assign s_axi.S_AXI_WREADY  = wstate_q == W_DATA;
  assign s_axi.S_AXI_BVALID  = wstate_q == W_RESP;
  assign s_axi.S_AXI_BRESP   = {s_axi.S_AXI_BVALID && werr_q, 1'b0};
  // Read path: issue -> registered memory read (p_*) -> 2-entry FIFO whose head drives R.
  rstate_t               rstate_q, rstate_d;
  logic [ADDR_WIDTH-1:0] rword_q, rword_d;
  logic                  rlow_q, rlow_d;
  logic [7:0]            rlen_q, rlen_d;
  logic [8:0]            riss_q, riss_d;
  logic                  p_q, p_d, p_err_q, p_err_d, p_last_q, p_last_d;
  logic [DATA_WIDTH-1:0] fdata_q [2];
  logic [DATA_WIDTH-1:0] fdata_d [2];
  logic [1:0]            ferr_q, ferr_d, flast_q, flast_d, fcnt_q, fcnt_d, occ;
  logic                  fwr_q, fwr_d, frd_q, frd_d, pop, issue;
  always_comb begin
    rstate_d = rstate_q;
    rword_d  = rword_q;
    rlow_d   = rlow_q;
    rlen_d   = rlen_q;
    riss_d   = riss_q;
    fdata_d  = fdata_q;
    ferr_d   = ferr_q;
    flast_d  = flast_q;
    pop      = fcnt_q != 2'd0 && s_axi.S_AXI_RREADY;
    occ      = fcnt_q + {1'b0, p_q} - {1'b0, pop};
    // occ counts slots committed after this edge, so an issue now always finds FIFO room two cycles on
    issue    = rstate_q == R_DATA && riss_q <= {1'b0, rlen_q} && occ != 2'd2;
    p_d      = issue;
    p_err_d  = rlow_q || rword_q >= DEPTH_A;
    p_last_d = riss_q[7:0] == rlen_q;
    fcnt_d   = occ;
    fwr_d    = fwr_q ^ p_q;
    frd_d    = frd_q ^ pop;
    if (issue) begin
      rword_d = rword_q + 1'b1;
      riss_d  = riss_q + 1'b1;
    end
    if (p_q) begin
      fdata_d[fwr_q] = p_err_q ? '0 : mem_rd_q;
      ferr_d[fwr_q]  = p_err_q;
      flast_d[fwr_q] = p_last_q;
    end
    case (rstate_q)
      R_INIT: rstate_d = R_IDLE;
      R_IDLE: if (s_axi.S_AXI_ARVALID) begin
        rstate_d = R_DATA;
        rword_d  = to_word(s_axi.S_AXI_ARADDR);
        rlow_d   = s_axi.S_AXI_ARADDR < BASE_ADDR;
        rlen_d   = s_axi.S_AXI_ARLEN;
        riss_d   = '0;
      end
      R_DATA: if (pop && flast_q[frd_q]) rstate_d = R_IDLE;
      default: rstate_d = R_INIT;
    endcase
  end
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rstate_q <= R_INIT;
      rword_q  <= '0;
      rlow_q   <= 1'b0;
      rlen_q   <= '0;
      riss_q   <= '0;
      p_q      <= 1'b0;
      p_err_q  <= 1'b0;
      p_last_q <= 1'b0;
      fdata_q  <= '{default: '0};
      ferr_q   <= '0;
      flast_q  <= '0;
      fcnt_q   <= '0;
      fwr_q    <= 1'b0;
      frd_q    <= 1'b0;
    end else begin
      rstate_q <= rstate_d;
      rword_q  <= rword_d;
      rlow_q   <= rlow_d;
      rlen_q   <= rlen_d;
      riss_q   <= riss_d;
      p_q      <= p_d;
      p_err_q  <= p_err_d;
      p_last_q <= p_last_d;
      fdata_q  <= fdata_d;
      ferr_q   <= ferr_d;
      flast_q  <= flast_d;
      fcnt_q   <= fcnt_d;
      fwr_q    <= fwr_d;
      frd_q    <= frd_d;
    end
  end
  // Nonblocking write and read in one block: a same-cycle read of the written word sees old data.
  always_ff @(posedge i_clk) begin
    if (mem_we)
      for (int b = 0; b < SB; b++)
        if (s_axi.S_AXI_WSTRB[b]) mem[wword_q[IW-1:0]][8*b +: 8] <= s_axi.S_AXI_WDATA[8*b +: 8];
    mem_rd_q <= mem[rword_q[IW-1:0]];
  end
  assign s_axi.S_AXI_ARREADY = rstate_q == R_IDLE;
  assign s_axi.S_AXI_RVALID  = fcnt_q != 2'd0;
  assign s_axi.S_AXI_RDATA   = fdata_q[frd_q];
  assign s_axi.S_AXI_RRESP   = {ferr_q[frd_q], 1'b0};
  assign s_axi.S_AXI_RLAST   = s_axi.S_AXI_RVALID && flast_q[frd_q];
endmodule

// File: tb/tb_tfhe_axi_slave_mem.sv
// tb_tfhe_axi_slave_mem: directed bursts against a bench-side word model of tfhe_axi_slave_mem
module tb_tfhe_axi_slave_mem;
  localparam logic [63:0] BASE = 64'h40000000;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int failures = 0;
  logic [31:0] model [1024];
  logic [31:0] pat = 32'b1011_0010_1110_0101_1001_0111_0100_1101;
  always #5 clk = ~clk;
  tfhe_axi_if bus ();
  tfhe_axi_slave_mem dut (.i_clk(clk), .i_reset(rst), .s_axi(bus));
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int widx(input logic [63:0] addr, input int i);
    longint w;
    if (addr < BASE) return -1;
    w = longint'((addr - BASE) >> 2) + i;
    return (w < 1024) ? int'(w) : -1;
  endfunction
  task automatic wr(input logic [63:0] addr, input logic [7:0] len, input logic [31:0] d0,
                    input logic [3:0] strb, input int lmode, output logic [1:0] resp);
    int n;
    int w;
    @(negedge clk);
    bus.S_AXI_AWADDR = addr; bus.S_AXI_AWLEN = len; bus.S_AXI_AWVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_AWREADY && n < 50) begin @(negedge clk); n++; end
    if (!bus.S_AXI_AWREADY) check("aw_timeout", bus.S_AXI_AWREADY, 1);
    @(posedge clk); #1 bus.S_AXI_AWVALID = 1'b0;
    for (int i = 0; i <= int'(len); i++) begin
      @(negedge clk);
      bus.S_AXI_WDATA = d0 + i; bus.S_AXI_WSTRB = strb; bus.S_AXI_WVALID = 1'b1;
      bus.S_AXI_WLAST = (lmode == 0) ? (i == int'(len)) : (lmode == 2) ? (i == 1) : 1'b0;
      n = 0;
      while (!bus.S_AXI_WREADY && n < 50) begin @(negedge clk); n++; end
      if (!bus.S_AXI_WREADY) check("w_timeout", bus.S_AXI_WREADY, 1);
      @(posedge clk);
      w = widx(addr, i);
      if (w >= 0)
        for (int b = 0; b < 4; b++) if (strb[b]) model[w][8*b +: 8] = bus.S_AXI_WDATA[8*b +: 8];
    end
    @(negedge clk);
    bus.S_AXI_WVALID = 1'b0; bus.S_AXI_WLAST = 1'b0;
    check("w_burst_end", bus.S_AXI_WREADY, 0);
    n = 0;
    while (!bus.S_AXI_BVALID && n < 50) begin @(negedge clk); n++; end
    check("b_valid", bus.S_AXI_BVALID, 1);
    resp = bus.S_AXI_BRESP;
    @(posedge clk);
  endtask
  task automatic ar(input logic [63:0] addr, input logic [7:0] len);
    int n;
    @(negedge clk);
    bus.S_AXI_ARADDR = addr; bus.S_AXI_ARLEN = len; bus.S_AXI_ARVALID = 1'b1;
    n = 0;
    while (!bus.S_AXI_ARREADY && n < 50) begin @(negedge clk); n++; end
    if (!bus.S_AXI_ARREADY) check("ar_timeout", bus.S_AXI_ARREADY, 1);
    @(posedge clk); #1 bus.S_AXI_ARVALID = 1'b0;
  endtask
  task automatic rd(input logic [63:0] addr, input logic [7:0] len, input bit rnd, output logic [31:0] first);
    int beat = 0, cyc = 0, lat = 0, first_cyc = 0, w;
    bit started = 0, stalled = 0, rr;
    logic [34:0] held = '0;
    logic [31:0] ed;
    first = '0;
    ar(addr, len);
    while (beat <= int'(len) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
      rr = rnd ? pat[cyc % 32] : 1'b1;
      bus.S_AXI_RREADY = rr;
      if (!bus.S_AXI_RVALID && !started) lat++;
      if (bus.S_AXI_RVALID) begin
        if (!started) begin started = 1; first_cyc = cyc; check("rd_latency", lat, 2); end
        if (stalled) check("rd_hold", {bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_RLAST}, held);
        if (rr) begin
          w = widx(addr, beat);
          ed = (w >= 0) ? model[w] : 32'h0;
          check("rd_beat", {bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_RLAST},
                {ed, (w >= 0) ? 2'b00 : 2'b10, beat == int'(len)});
          if (beat == 0) first = bus.S_AXI_RDATA;
          beat++;
          stalled = 0;
        end else begin
          stalled = 1;
          held = {bus.S_AXI_RDATA, bus.S_AXI_RRESP, bus.S_AXI_RLAST};
        end
      end
    end
    if (beat <= int'(len)) check("rd_timeout", beat, len + 1);
    if (!rnd) check("rd_back_to_back", cyc - first_cyc + 1, len + 1);
    @(negedge clk);
    bus.S_AXI_RREADY = 1'b0;
    check("rd_after_last", {bus.S_AXI_RVALID, bus.S_AXI_ARREADY}, 2'b01);
  endtask
  initial begin
    logic [1:0] resp;
    logic [31:0] first;
    int n, got;
    bus.S_AXI_AWADDR = '0; bus.S_AXI_AWLEN = '0; bus.S_AXI_AWVALID = 0;
    bus.S_AXI_WDATA = '0; bus.S_AXI_WSTRB = '0; bus.S_AXI_WLAST = 0; bus.S_AXI_WVALID = 0;
    bus.S_AXI_BREADY = 1; bus.S_AXI_ARADDR = '0; bus.S_AXI_ARLEN = '0; bus.S_AXI_ARVALID = 0;
    bus.S_AXI_RREADY = 0;
    for (int i = 0; i < 1024; i++) model[i] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", {bus.S_AXI_AWREADY, bus.S_AXI_WREADY, bus.S_AXI_BVALID, bus.S_AXI_BRESP,
          bus.S_AXI_ARREADY, bus.S_AXI_RVALID, bus.S_AXI_RLAST, bus.S_AXI_RRESP, bus.S_AXI_RDATA}, '0);
    rst = 1'b0;
    #1 check("ready_before_edge", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 2'b00);
    @(posedge clk); #1 check("ready_after_edge", {bus.S_AXI_AWREADY, bus.S_AXI_ARREADY}, 2'b11);
    wr(BASE + 64'h40, 8'd15, 32'd0, 4'hF, 0, resp);
    check("t1_bresp", resp, 2'b00);
    rd(BASE + 64'h40, 8'd15, 0, first);
    check("t1_first", first, 32'd0);
    wr(BASE, 8'd0, 32'hFFFFFFFF, 4'hF, 0, resp);
    check("t2_bresp_a", resp, 2'b00);
    wr(BASE, 8'd0, 32'h12345678, 4'h3, 0, resp);
    check("t2_bresp_b", resp, 2'b00);
    rd(BASE, 8'd0, 0, first);
    check("t2_strobe_merge", first, 32'hFFFF5678);
    rd(BASE + 64'h40, 8'd15, 1, first);
    check("t3_first", first, 32'd0);
    wr(BASE + 64'd4088, 8'd3, 32'hA0, 4'hF, 0, resp);
    check("t4_bresp", resp, 2'b10);
    rd(BASE + 64'd4088, 8'd3, 0, first);
    check("t4_first", first, 32'hA0);
    wr(BASE + 64'h100, 8'd3, 32'hC0, 4'hF, 1, resp);
    check("t5_wlast_low", resp, 2'b10);
    wr(BASE + 64'h110, 8'd3, 32'hD0, 4'hF, 2, resp);
    check("t5_wlast_early", resp, 2'b10);
    rd(BASE + 64'h110, 8'd3, 0, first);
    check("t5_first", first, 32'hD0);
    ar(BASE + 64'h40, 8'd15);
    bus.S_AXI_RREADY = 1'b1;
    n = 0; got = 0;
    while (got < 5 && n < 200) begin
      @(negedge clk);
      n++;
      if (bus.S_AXI_RVALID) begin
        if (got == 4) begin
          rst = 1'b1;
          #1 check("t6_async_rvalid", bus.S_AXI_RVALID, 0);
          check("t6_async_outs", {bus.S_AXI_ARREADY, bus.S_AXI_AWREADY, bus.S_AXI_RLAST,
                bus.S_AXI_RRESP, bus.S_AXI_RDATA}, '0);
        end
        got++;
      end
    end
    check("t6_reached_beat5", got, 5);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    bus.S_AXI_RREADY = 1'b0;
    #1 check("t6_arready_pre", bus.S_AXI_ARREADY, 0);
    @(posedge clk); #1 check("t6_arready_post", bus.S_AXI_ARREADY, 1);
    rd(BASE + 64'h40, 8'd15, 0, first);
    check("t6_reread_first", first, 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tfhe_axi_slave_mem.md
Name: tfhe_axi_slave_mem

Overview:
AXI4 full slave (responder) backed by an internal word-addressed memory. It is the ciphertext and key buffer that the TFHE PBS accelerator's AXI4 master reads from and writes to, and it doubles as the bench-side memory model for that master. It supports INCR bursts of up to 256 beats on independent read and write channels, with one outstanding transaction per direction.

Parameters:
DATA_WIDTH, 32, data bus width in bits; a power of 2, at least 32.
ADDR_WIDTH, 64, address bus width in bits.
BASE_ADDR, 64'h40000000, byte address that maps to memory word 0.
DEPTH, 1024, number of memory words; a power of 2.

Ports:
i_clk  in  1  clock; all logic is on the rising edge.
i_reset  in  1  asynchronous, active-high reset.
S_AXI_AWADDR  in  ADDR_WIDTH  write burst start byte address.
S_AXI_AWLEN  in  8  write beats minus 1.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
S_AXI_WDATA  in  DATA_WIDTH  write data.
S_AXI_WSTRB  in  DATA_WIDTH/8  byte enables.
S_AXI_WLAST  in  1  last write beat.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
S_AXI_BRESP  out  2  write response: 00 OKAY, 10 SLVERR.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
S_AXI_ARADDR  in  ADDR_WIDTH  read burst start byte address.
S_AXI_ARLEN  in  8  read beats minus 1.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
S_AXI_RDATA  out  DATA_WIDTH  read data.
S_AXI_RRESP  out  2  per-beat read response.
S_AXI_RLAST  out  1  last read beat.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.

Behaviour:
- Burst type, size and ID are fixed by decision: INCR only, full-width beats, ID 0. The block has no AxBURST, AxSIZE or ID ports.
- Address mapping: off = addr - BASE_ADDR; word = off >> log2(DATA_WIDTH/8); the low offset bits are ignored. Each beat uses word+1 relative to the previous beat.
- A beat is in range when word < DEPTH, computed at full ADDR_WIDTH with no wrap. An address below BASE_ADDR counts as out of range.
- Reset (asynchronous): AWREADY, WREADY, BVALID, ARREADY, RVALID and RLAST are 0; BRESP, RRESP and RDATA are 0. Both FSMs go to IDLE and any in-flight burst is discarded. Memory contents are not cleared.
- After i_reset deasserts, AWREADY and ARREADY rise on the first clock edge.
- Write FSM:
  - W_IDLE (AWREADY=1): on AW handshake, latch word and AWLEN, clear the error flag, go to W_DATA.
  - W_DATA (WREADY=1): each W handshake writes the bytes enabled by WSTRB if the beat is in range; an out-of-range beat sets the error flag and is dropped.
  - The burst ends on beat count == AWLEN. WLAST low on that beat, or high on any earlier beat, sets the error flag. The beat count alone terminates the burst.
  - At the end of the burst, go to W_RESP.
  - W_RESP: BVALID=1, BRESP = error ? 10 : 00. On BREADY, go to W_IDLE.
  - AWREADY is 0 outside W_IDLE.
- Read FSM:
  - R_IDLE (ARREADY=1): on AR handshake, latch word and ARLEN, go to R_DATA.
  - First RVALID appears exactly 2 cycles after the AR handshake; memory read is synchronous, 1 cycle.
  - Throughput: one beat per cycle while RREADY stays high, implemented with a 2-entry skid or prefetch.
  - While RVALID=1 and RREADY=0, RDATA, RRESP and RLAST must hold stable. No beat may be lost or duplicated.
  - Out-of-range beat: RDATA=0, RRESP=10. In-range beat: RRESP=00.
  - RLAST=1 on beat ARLEN only. After that beat's handshake, go to R_IDLE; ARREADY returns the next cycle.
- Read and write channels are fully concurrent. If a read and a write hit the same word in the same cycle, the read returns the old data.
- AWLEN=0 or ARLEN=0 is a valid single-beat burst. AWLEN=255 is a valid 256-beat burst.

Test Plan:
1. Write AWADDR=BASE+0x40, AWLEN=15, data 0..15, WSTRB all ones, BREADY=1 -> BRESP=00. Then read with ARADDR=BASE+0x40, ARLEN=15, RREADY=1 -> RDATA 0..15 on 16 consecutive cycles, first beat 2 cycles after AR, RLAST on beat 15 only.
2. Write 0xFFFFFFFF to BASE. Then write 0x12345678 with WSTRB=0011 to the same word. Read BASE -> 0xFFFF5678.
3. Replay the read from test 1 with RREADY toggling in a pseudo-random pattern -> 16 beats exactly, data 0..15 in order, outputs stable during every stall.
4. Write AWADDR=BASE+DEPTH*4-8 (32-bit data), AWLEN=3 -> BRESP=10, words DEPTH-2 and DEPTH-1 updated. Read the same range -> RRESP 00,00,10,10; last two beats RDATA=0.
5. Write AWLEN=3 with WLAST held low -> 4 beats accepted, BRESP=10. A separate write with AWLEN=3 and WLAST high on beat 1 -> 4 beats accepted, BRESP=10.
6. Assert i_reset during beat 5 of a 16-beat read -> RVALID=0 immediately (asynchronous). After release, ARREADY=1 on the next edge, and a re-read returns the original data.
